fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of PC and instruction address.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, width of a fetched instruction.
REQ-003 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-006 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-008 SHALL have port fetch_en_i  input  1  permits a fetch this cycle.
REQ-009 SHALL have port redirect_i  input  1  taken branch/jump from execute (PCSrcE).
REQ-010 SHALL have port PCTarget_i  input  PC_WIDTH  redirect address (PCTargetE).
REQ-011 SHALL have port PCF_o  output  PC_WIDTH  current fetch address to instruction memory.
REQ-012 SHALL have port InstrF_i  input  INSTRUCTION_WIDTH  combinational instruction memory read data for PCF_o.
REQ-013 SHALL have port valid_o  output  1  head entry present.
REQ-014 SHALL have port ready_i  input  1  decode consumes head this cycle.
REQ-015 SHALL have port PCD_o  output  PC_WIDTH  head entry PC.
REQ-016 SHALL have port InstrD_o  output  INSTRUCTION_WIDTH  head entry instruction.
REQ-017 SHALL have port PCPlus4D_o  output  PC_WIDTH  head entry PC+4.
REQ-018 SHALL have port count_o  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-019 SHALL define full = (count == DEPTH) and empty = (count == 0), from registered count only.
REQ-020 SHALL push when fetch_en_i & ~full & ~redirect_i: write {PCF_o, InstrF_i, PCF_o+4} at tail, tail+1, PC <= PCF_o+4.
REQ-021 SHALL hold PC and tail when no push and no redirect.
REQ-022 SHALL pop when valid_o & ready_i & ~redirect_i: head+1.
REQ-023 SHALL drive valid_o = ~empty combinationally from registered state.
REQ-024 SHALL drive PCD_o/InstrD_o/PCPlus4D_o from head entry when valid_o=1; else 0 / 32'h0000_0013 (NOP) / 0.
REQ-025 SHALL block push when full even if a pop occurs the same cycle (no pass-through).
REQ-026 SHALL keep count unchanged on simultaneous push and pop; +1 push only; -1 pop only.
REQ-027 SHALL wrap head/tail pointers modulo DEPTH.
REQ-028 SHALL compute PC+4 modulo 2^PC_WIDTH (0xFFFF_FFFC -> 0x0000_0000).
REQ-029 SHALL, on redirect_i, set count/head/tail to 0 and PC <= PCTarget_i at that edge, discarding any push/pop that cycle.
REQ-030 SHALL give fetch-to-output latency of one cycle: entry pushed at edge N has valid_o=1 in cycle N+1 if it is the head.
REQ-031 SHALL ignore ready_i while valid_o=0.

Reset
REQ-032 SHALL, on rst_i assertion (asynchronous, mid-operation included), immediately set PC=RESET_PC, count=0, head=tail=0, valid_o=0.
REQ-033 SHALL not require storage entries to be cleared by reset.
REQ-034 SHALL resume fetching at RESET_PC on the first rising edge after rst_i deasserts with fetch_en_i=1.

Verification
REQ-035 SHALL verify reset: rst_i=1 -> PCF_o=0, valid_o=0, count_o=0, InstrD_o=0x00000013.
REQ-036 SHALL verify streaming: fetch_en_i=1, ready_i=1, InstrF_i=mem[PC] -> PCD_o=0,4,8,... one per cycle from cycle 1, count_o stays 1.
REQ-037 SHALL verify fill: ready_i=0 for 6 cycles -> count_o saturates at 4, PCF_o holds 0x10, no overwrite; ready_i=1 drains PCs 0,4,8,C in order.
REQ-038 SHALL verify redirect: queue holding 3 entries, redirect_i=1, PCTarget_i=0x40 -> next cycle count_o=0, PCF_o=0x40; following cycle PCD_o=0x40, valid_o=1.
REQ-039 SHALL verify simultaneous push/pop with count=2 -> count_o stays 2; with count=4 -> count_o becomes 3.
REQ-040 SHALL verify wrap: PC=0xFFFF_FFFC push -> PCPlus4D_o=0, next PCF_o=0; reset asserted mid-drain -> valid_o falls without a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch stage with a small decoupling queue between fetch and
// decode. Each cycle the fetch PC is presented to a combinational instruction
// memory. When fetching is permitted, the queue has room and no redirect is
// pending, the PC, returned instruction and PC+4 are written at the tail, and
// the PC advances. Decode sees the head entry and consumes it with ready_i.
// A redirect from execute flushes the queue and restarts fetch at the target.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_i        : asynchronous active-high reset
//   fetch_en_i   : a fetch is permitted this cycle
//   redirect_i   : taken branch/jump from execute
//   PCTarget_i   : redirect address
//   PCF_o        : current fetch address to instruction memory
//   InstrF_i     : instruction memory read data for PCF_o (combinational)
//   valid_o      : head entry present
//   ready_i      : decode consumes the head entry this cycle
//   PCD_o        : head entry PC            (0 when empty)
//   InstrD_o     : head entry instruction   (NOP 0x00000013 when empty)
//   PCPlus4D_o   : head entry PC+4          (0 when empty)
//   count_o      : number of occupied entries
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                 PC_WIDTH          = 32,
    parameter int                 INSTRUCTION_WIDTH = 32,
    parameter int                 DEPTH             = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC         = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         fetch_en_i,
    input  logic                         redirect_i,
    input  logic [PC_WIDTH-1:0]          PCTarget_i,
    output logic [PC_WIDTH-1:0]          PCF_o,
    input  logic [INSTRUCTION_WIDTH-1:0] InstrF_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [PC_WIDTH-1:0]          PCD_o,
    output logic [INSTRUCTION_WIDTH-1:0] InstrD_o,
    output logic [PC_WIDTH-1:0]          PCPlus4D_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR = INSTRUCTION_WIDTH'(32'h0000_0013);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_WIDTH-1:0] pc_q,    pc_d;
    logic [AW-1:0]       head_q,  head_d;
    logic [AW-1:0]       tail_q,  tail_d;
    logic [CW-1:0]       count_q, count_d;

    // Entry storage; not reset, since count/head/tail define which entries
    // are meaningful.
    logic [PC_WIDTH-1:0]          pc_mem    [DEPTH];
    logic [INSTRUCTION_WIDTH-1:0] instr_mem [DEPTH];
    logic [PC_WIDTH-1:0]          pc4_mem   [DEPTH];

    // ------------------------------------------------------------------
    // Status and handshakes (derived from registered count only)
    // ------------------------------------------------------------------
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] pc_plus4;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign valid_o  = ~empty;

    // A full queue refuses the push even if the head is popped in the same
    // cycle: there is no fall-through path from fetch to decode.
    assign push     = fetch_en_i & ~full & ~redirect_i;
    assign pop      = valid_o & ready_i & ~redirect_i;

    // Wraps naturally modulo 2^PC_WIDTH.
    assign pc_plus4 = pc_q + PC_WIDTH'(4);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (redirect_i) begin
            // Flush: anything fetched down the wrong path is discarded,
            // including a push or pop that would have happened this cycle.
            pc_d    = PCTarget_i;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_plus4;
                tail_d = tail_q + AW'(1);   // wraps modulo DEPTH
            end
            if (pop) begin
                head_d = head_q + AW'(1);   // wraps modulo DEPTH
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage write
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[tail_q]    <= pc_q;
            instr_mem[tail_q] <= InstrF_i;
            pc4_mem[tail_q]   <= pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Head read is asynchronous so an entry written at one edge is visible
    // to decode in the very next cycle.
    always_comb begin
        PCD_o      = '0;
        InstrD_o   = NOP_INSTR;
        PCPlus4D_o = '0;
        if (valid_o) begin
            PCD_o      = pc_mem[head_q];
            InstrD_o   = instr_mem[head_q];
            PCPlus4D_o = pc4_mem[head_q];
        end
    end

    assign PCF_o   = pc_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//
// Directed table of per-cycle vectors for fetch_queue: inputs applied before
// a rising edge, outputs compared shortly after it. Multi-cycle corner cases
// (power-on reset, asynchronous reset mid-drain, restart) are hand-written.
// The instruction memory is a fixed function of the address.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int PW = 32;
    localparam int IW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [IW-1:0] NOP = 32'h0000_0013;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          fetch_en_i;
    logic          redirect_i;
    logic [PW-1:0] PCTarget_i;
    logic [PW-1:0] PCF_o;
    logic [IW-1:0] InstrF_i;
    logic          valid_o;
    logic          ready_i;
    logic [PW-1:0] PCD_o;
    logic [IW-1:0] InstrD_o;
    logic [PW-1:0] PCPlus4D_o;
    logic [CW-1:0] count_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    // Instruction memory: a distinctive pattern derived from the address.
    function automatic logic [IW-1:0] imem(input logic [PW-1:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    assign InstrF_i = imem(PCF_o);

    fetch_queue #(
        .PC_WIDTH(PW),
        .INSTRUCTION_WIDTH(IW),
        .DEPTH(DEPTH),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .fetch_en_i(fetch_en_i),
        .redirect_i(redirect_i),
        .PCTarget_i(PCTarget_i),
        .PCF_o(PCF_o),
        .InstrF_i(InstrF_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .PCD_o(PCD_o),
        .InstrD_o(InstrD_o),
        .PCPlus4D_o(PCPlus4D_o),
        .count_o(count_o)
    );

    typedef struct {
        string         name;
        logic          fetch_en;
        logic          redirect;
        logic [PW-1:0] target;
        logic          ready;
        logic [PW-1:0] exp_pcf;
        logic          exp_valid;
        logic [CW-1:0] exp_count;
        logic [PW-1:0] exp_pcd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic fe, input logic rd,
                       input logic [PW-1:0] tg, input logic rdy,
                       input logic [PW-1:0] pcf, input logic v,
                       input int cnt, input logic [PW-1:0] pcd);
        vec_t t;
        t.name = nm; t.fetch_en = fe; t.redirect = rd; t.target = tg;
        t.ready = rdy; t.exp_pcf = pcf; t.exp_valid = v;
        t.exp_count = CW'(cnt); t.exp_pcd = pcd;
        vecs.push_back(t);
    endtask

    task automatic check32(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Full output check; head-derived outputs follow from the expected PC.
    task automatic check_all(input string nm, input logic [PW-1:0] pcf, input logic v,
                             input logic [CW-1:0] cnt, input logic [PW-1:0] pcd);
        logic [IW-1:0] ei;
        logic [PW-1:0] e4;
        ei = v ? imem(pcd) : NOP;
        e4 = v ? pcd + 32'd4 : 32'd0;
        check32({nm, ".PCF"},      PCF_o, pcf);
        check32({nm, ".valid"},    {31'd0, valid_o}, {31'd0, v});
        check32({nm, ".count"},    32'(count_o), 32'(cnt));
        check32({nm, ".PCD"},      PCD_o, v ? pcd : 32'd0);
        check32({nm, ".InstrD"},   InstrD_o, ei);
        check32({nm, ".PCPlus4D"}, PCPlus4D_o, e4);
        $display("[TB] %-14s PCF=%08h valid=%0b count=%0d PCD=%08h InstrD=%08h PC4=%08h",
                 nm, PCF_o, valid_o, count_o, PCD_o, InstrD_o, PCPlus4D_o);
    endtask

    initial begin
        //    name            fe rd target        rdy  PCF           v  cnt PCD
        // Streaming: ready ignored while empty, then one entry per cycle
        add("stream0",        1, 0, 32'h0,        1,   32'h4,        1, 1, 32'h0);
        add("stream1",        1, 0, 32'h0,        1,   32'h8,        1, 1, 32'h4);
        add("stream2",        1, 0, 32'h0,        1,   32'hC,        1, 1, 32'h8);
        add("stream3",        1, 0, 32'h0,        1,   32'h10,       1, 1, 32'hC);
        // Redirect back to 0 for a clean fill
        add("redir0",         1, 1, 32'h0,        1,   32'h0,        0, 0, 32'h0);
        // Fill for 6 cycles with decode stalled
        add("fill1",          1, 0, 32'h0,        0,   32'h4,        1, 1, 32'h0);
        add("fill2",          1, 0, 32'h0,        0,   32'h8,        1, 2, 32'h0);
        add("fill3",          1, 0, 32'h0,        0,   32'hC,        1, 3, 32'h0);
        add("fill4",          1, 0, 32'h0,        0,   32'h10,       1, 4, 32'h0);
        add("fill5",          1, 0, 32'h0,        0,   32'h10,       1, 4, 32'h0);
        add("fill6",          1, 0, 32'h0,        0,   32'h10,       1, 4, 32'h0);
        // Drain in order without fetching
        add("drain1",         0, 0, 32'h0,        1,   32'h10,       1, 3, 32'h4);
        add("drain2",         0, 0, 32'h0,        1,   32'h10,       1, 2, 32'h8);
        add("drain3",         0, 0, 32'h0,        1,   32'h10,       1, 1, 32'hC);
        add("drain4",         0, 0, 32'h0,        1,   32'h10,       0, 0, 32'h0);
        add("drain_idle",     0, 0, 32'h0,        1,   32'h10,       0, 0, 32'h0);
        // Refill to full across the pointer wrap
        add("refill1",        1, 0, 32'h0,        0,   32'h14,       1, 1, 32'h10);
        add("refill2",        1, 0, 32'h0,        0,   32'h18,       1, 2, 32'h10);
        add("refill3",        1, 0, 32'h0,        0,   32'h1C,       1, 3, 32'h10);
        add("refill4",        1, 0, 32'h0,        0,   32'h20,       1, 4, 32'h10);
        // Push+pop when full: push blocked, count 4 -> 3
        add("pp_full",        1, 0, 32'h0,        1,   32'h20,       1, 3, 32'h14);
        add("pp_cnt3",        1, 0, 32'h0,        1,   32'h24,       1, 3, 32'h18);
        add("pop_to2",        0, 0, 32'h0,        1,   32'h24,       1, 2, 32'h1C);
        // Push+pop with count 2: count unchanged
        add("pp_cnt2",        1, 0, 32'h0,        1,   32'h28,       1, 2, 32'h20);
        add("push_to3",       1, 0, 32'h0,        0,   32'h2C,       1, 3, 32'h20);
        // Redirect with 3 entries; push/pop that cycle discarded
        add("redir40",        1, 1, 32'h40,       1,   32'h40,       0, 0, 32'h0);
        add("after_redir",    1, 0, 32'h0,        0,   32'h44,       1, 1, 32'h40);
        // PC wrap at the top of the address space
        add("redir_top",      1, 1, 32'hFFFF_FFFC, 0,  32'hFFFF_FFFC, 0, 0, 32'h0);
        add("wrap_push",      1, 0, 32'h0,        0,   32'h0,        1, 1, 32'hFFFF_FFFC);
        add("wrap_pp",        1, 0, 32'h0,        1,   32'h4,        1, 1, 32'h0);
        add("wrap_push2",     1, 0, 32'h0,        0,   32'h8,        1, 2, 32'h0);

        // Power-on reset, checked asynchronously before any clock edge
        rst_i = 1'b1; fetch_en_i = 1'b0; redirect_i = 1'b0;
        PCTarget_i = '0; ready_i = 1'b0;
        #2;
        check_all("reset", 32'h0, 1'b0, '0, 32'h0);
        #1;
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            fetch_en_i = vecs[i].fetch_en;
            redirect_i = vecs[i].redirect;
            PCTarget_i = vecs[i].target;
            ready_i    = vecs[i].ready;
            @(posedge clk_i);
            #1;
            check_all(vecs[i].name, vecs[i].exp_pcf, vecs[i].exp_valid,
                      vecs[i].exp_count, vecs[i].exp_pcd);
        end

        // Explicit wrap check: entry at 0xFFFFFFFC must carry PC+4 = 0.
        // Reached again by redirect so the head is that entry.
        fetch_en_i = 1'b1; redirect_i = 1'b1; PCTarget_i = 32'hFFFF_FFFC; ready_i = 1'b0;
        @(posedge clk_i); #1;
        redirect_i = 1'b0;
        @(posedge clk_i); #1;
        check32("wrap.PCPlus4D", PCPlus4D_o, 32'h0);
        check32("wrap.PCF", PCF_o, 32'h0);
        @(posedge clk_i); #1;
        check32("wrap.count", 32'(count_o), 32'd2);

        // Asynchronous reset mid-drain: outputs must clear with no clock edge
        ready_i = 1'b1; fetch_en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_all("async_rst", 32'h0, 1'b0, '0, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        fetch_en_i = 1'b1; ready_i = 1'b0;
        @(posedge clk_i); #1;
        check_all("restart", 32'h4, 1'b1, CW'(1), 32'h0);
        @(posedge clk_i); #1;
        check_all("restart2", 32'h8, 1'b1, CW'(2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit 100000 reached");
        $fatal(1, "timeout");
    end

endmodule
